// File: rtl/uart_tx_arbiter.sv
// Two-source arbiter in front of a single UART byte transmitter.
// Each granted word is sent MSB byte first and never interleaved with the other source.
module uart_tx_arbiter #(
   parameter int BYTES_PER_WORD = 2,
   parameter bit RR_EN          = 1'b1
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        req0_valid_i,
   input  logic [8*BYTES_PER_WORD-1:0] req0_data_i,
   output logic                        req0_ready_o,
   input  logic                        req1_valid_i,
   input  logic [8*BYTES_PER_WORD-1:0] req1_data_i,
   output logic                        req1_ready_o,
   input  logic                        tx_busy_i,
   output logic                        tx_start_o,
   output logic [7:0]                  tx_byte_o,
   output logic [1:0]                  grant_o,
   output logic                        idle_o
);

   localparam int W  = 8 * BYTES_PER_WORD;
   localparam int CW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
   localparam logic [CW-1:0] LAST_BYTE = CW'(BYTES_PER_WORD - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      HOLD  = 2'd2,
      WAIT  = 2'd3
   } state_t;

   state_t          state_r, state_nxt_s;
   logic [W-1:0]    shift_r, shift_nxt_s;
   logic [CW-1:0]   byte_cnt_r, byte_cnt_nxt_s;
   logic            last_grant_r, last_grant_nxt_s;
   logic [1:0]      grant_r, grant_nxt_s;
   logic [7:0]      tx_byte_r, tx_byte_nxt_s;
   logic            ready0_s, ready1_s;
   logic            pick1_s;
   logic [W-1:0]    sel_data_s;
   logic [W-1:0]    shifted_s;

   // last_grant_r is 1 after reset, so the first tie goes to source 0.
   assign pick1_s    = req1_valid_i && (!req0_valid_i || ((RR_EN == 1'b1) && !last_grant_r));
   assign sel_data_s = pick1_s ? req1_data_i : req0_data_i;
   assign shifted_s  = shift_r << 8;

   // State and datapath registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r      <= IDLE;
         shift_r      <= {W{1'b0}};
         byte_cnt_r   <= {CW{1'b0}};
         last_grant_r <= 1'b1;
         grant_r      <= 2'b00;
         tx_byte_r    <= 8'h00;
      end else begin
         state_r      <= state_nxt_s;
         shift_r      <= shift_nxt_s;
         byte_cnt_r   <= byte_cnt_nxt_s;
         last_grant_r <= last_grant_nxt_s;
         grant_r      <= grant_nxt_s;
         tx_byte_r    <= tx_byte_nxt_s;
      end
   end

   // Next-state, arbitration and byte sequencing.
   always_comb begin
      state_nxt_s      = state_r;
      shift_nxt_s      = shift_r;
      byte_cnt_nxt_s   = byte_cnt_r;
      last_grant_nxt_s = last_grant_r;
      grant_nxt_s      = grant_r;
      tx_byte_nxt_s    = tx_byte_r;
      ready0_s         = 1'b0;
      ready1_s         = 1'b0;
      case (state_r)
         IDLE: begin
            if (!tx_busy_i && (req0_valid_i || req1_valid_i)) begin
               ready0_s         = !pick1_s;
               ready1_s         = pick1_s;
               shift_nxt_s      = sel_data_s;
               byte_cnt_nxt_s   = {CW{1'b0}};
               last_grant_nxt_s = pick1_s;
               grant_nxt_s      = pick1_s ? 2'b10 : 2'b01;
               tx_byte_nxt_s    = sel_data_s[W-1 -: 8];
               state_nxt_s      = START;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         START: state_nxt_s = HOLD;
         // The UART only raises busy the cycle after start, so HOLD skips one look.
         HOLD:  state_nxt_s = WAIT;
         WAIT: begin
            if (tx_busy_i) begin
               state_nxt_s = WAIT;
            end else if (byte_cnt_r == LAST_BYTE) begin
               grant_nxt_s = 2'b00;
               state_nxt_s = IDLE;
            end else begin
               shift_nxt_s    = shifted_s;
               byte_cnt_nxt_s = byte_cnt_r + CW'(1);
               tx_byte_nxt_s  = shifted_s[W-1 -: 8];
               state_nxt_s    = START;
            end
         end
         default: begin
            grant_nxt_s = 2'b00;
            state_nxt_s = IDLE;
         end
      endcase
   end

   assign req0_ready_o = ready0_s;
   assign req1_ready_o = ready1_s;
   assign tx_start_o   = (state_r == START);
   assign tx_byte_o    = tx_byte_r;
   assign grant_o      = grant_r;
   assign idle_o       = (state_r == IDLE);

endmodule
